// File: rtl/alu_pkg.sv
// Shared widths and opcode constants for the execute-stage ALU and its bench.
package alu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int OPRN_WIDTH = 6;

    localparam logic [OPRN_WIDTH-1:0] OPRN_ADD = 6'h01;
    localparam logic [OPRN_WIDTH-1:0] OPRN_SUB = 6'h02;
    localparam logic [OPRN_WIDTH-1:0] OPRN_MUL = 6'h03;
    localparam logic [OPRN_WIDTH-1:0] OPRN_SRL = 6'h04;
    localparam logic [OPRN_WIDTH-1:0] OPRN_SLL = 6'h05;
    localparam logic [OPRN_WIDTH-1:0] OPRN_AND = 6'h06;
    localparam logic [OPRN_WIDTH-1:0] OPRN_OR  = 6'h07;
    localparam logic [OPRN_WIDTH-1:0] OPRN_NOR = 6'h08;
    localparam logic [OPRN_WIDTH-1:0] OPRN_SLT = 6'h09;

endpackage

// File: rtl/alu_barrel_shift.sv
// Combinational log2(DATA_WIDTH)-stage logical barrel shifter, left or right.
// Amounts of DATA_WIDTH or more give an all-zero result.
module alu_barrel_shift
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] amount,
    input  logic                  dir_left,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int STAGES = $clog2(DATA_WIDTH);

    logic [STAGES:0][DATA_WIDTH-1:0] stage_s;
    logic                            out_of_range_s;

    assign stage_s[0]     = data;
    assign out_of_range_s = (amount >= DATA_WIDTH'(DATA_WIDTH));

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int STEP = 1 << i;
        assign stage_s[i+1] = !amount[i] ? stage_s[i]
                            : (dir_left ? (stage_s[i] << STEP) : (stage_s[i] >> STEP));
    end

    // Out-of-range amounts override whatever the stages produced.
    always_comb begin
        if (out_of_range_s) begin
            result = {DATA_WIDTH{1'b0}};
        end else begin
            result = stage_s[STAGES];
        end
    end

endmodule

// File: rtl/alu.sv
// Single-cycle integer ALU with registered result and zero flag.
// Define ALU_MUL_EN to build the multiplier; otherwise MUL yields zero.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int OPRN_WIDTH = alu_pkg::OPRN_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] OP1,
    input  logic [DATA_WIDTH-1:0] OP2,
    input  logic [OPRN_WIDTH-1:0] OPRN,
    output logic [DATA_WIDTH-1:0] OUT,
    output logic                  ZERO
);

    logic [DATA_WIDTH-1:0] sum_s;
    logic [DATA_WIDTH-1:0] diff_s;
    logic [DATA_WIDTH-1:0] shift_s;
    logic [DATA_WIDTH-1:0] result_s;
    logic [DATA_WIDTH-1:0] out_r;
    logic                  zero_r;

    assign sum_s  = OP1 + OP2;
    assign diff_s = OP1 - OP2;

    alu_barrel_shift #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shift (
        .data    (OP1),
        .amount  (OP2),
        .dir_left(OPRN == OPRN_SLL),
        .result  (shift_s)
    );

`ifdef ALU_MUL_EN
    logic [DATA_WIDTH-1:0] prod_s;

    // Low half of the product is sign-agnostic, so an unsigned multiply suffices.
    assign prod_s = OP1 * OP2;
`else
    localparam logic [DATA_WIDTH-1:0] PROD_DISABLED = {DATA_WIDTH{1'b0}};
`endif

    // Operation select; unsupported codes produce zero.
    always_comb begin
        result_s = {DATA_WIDTH{1'b0}};
        case (OPRN)
            OPRN_ADD: result_s = sum_s;
            OPRN_SUB: result_s = diff_s;
`ifdef ALU_MUL_EN
            OPRN_MUL: result_s = prod_s;
`else
            OPRN_MUL: result_s = PROD_DISABLED;
`endif
            OPRN_SRL: result_s = shift_s;
            OPRN_SLL: result_s = shift_s;
            OPRN_AND: result_s = OP1 & OP2;
            OPRN_OR:  result_s = OP1 | OP2;
            OPRN_NOR: result_s = ~(OP1 | OP2);
            OPRN_SLT: result_s = {{(DATA_WIDTH-1){1'b0}}, (OP1 < OP2)};
            default:  result_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Output register; zero flag comes from the same next-state value.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_r  <= {DATA_WIDTH{1'b0}};
            zero_r <= 1'b1;
        end else begin
            out_r  <= result_s;
            zero_r <= (result_s == {DATA_WIDTH{1'b0}});
        end
    end

    assign OUT  = out_r;
    assign ZERO = zero_r;

endmodule

// File: tb/tb_alu.sv
// Directed scoreboard bench for the alu top; MUL expectations follow ALU_MUL_EN.
module tb_alu;
    import alu_pkg::*;

    logic                  CLK;
    logic                  RST;
    logic [DATA_WIDTH-1:0] OP1;
    logic [DATA_WIDTH-1:0] OP2;
    logic [OPRN_WIDTH-1:0] OPRN;
    logic [DATA_WIDTH-1:0] OUT;
    logic                  ZERO;

    logic [DATA_WIDTH-1:0] exp_q[$];
    string                 tag_q[$];
    int                    test_cnt = 0;
    int                    fail_cnt = 0;

    alu #(
        .DATA_WIDTH(DATA_WIDTH),
        .OPRN_WIDTH(OPRN_WIDTH)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .OP1 (OP1),
        .OP2 (OP2),
        .OPRN(OPRN),
        .OUT (OUT),
        .ZERO(ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_out();
        logic [DATA_WIDTH-1:0] exp;
        string                 tag;
        test_cnt++;
        assert (exp_q.size() > 0) else begin
            fail_cnt++;
            $error("FAIL scoreboard_empty: observed OUT=%h with no expected entry", OUT);
        end
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            test_cnt++;
            assert (OUT === exp) else begin
                fail_cnt++;
                $error("FAIL %s: OUT observed %h expected %h", tag, OUT, exp);
            end
            test_cnt++;
            assert (ZERO === (exp == 32'h0)) else begin
                fail_cnt++;
                $error("FAIL %s_zero: ZERO observed %b expected %b", tag, ZERO, (exp == 32'h0));
            end
        end
    endtask

    task automatic check_rst(input string tag);
        test_cnt++;
        assert (OUT === 32'h0) else begin
            fail_cnt++;
            $error("FAIL %s: OUT observed %h expected %h", tag, OUT, 32'h0);
        end
        test_cnt++;
        assert (ZERO === 1'b1) else begin
            fail_cnt++;
            $error("FAIL %s_zero: ZERO observed %b expected %b", tag, ZERO, 1'b1);
        end
    endtask

    task automatic step(input string tag, input logic [OPRN_WIDTH-1:0] op,
                        input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                        input logic [DATA_WIDTH-1:0] exp);
        @(negedge CLK);
        OPRN = op;
        OP1  = a;
        OP2  = b;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge CLK);
        #1;
        check_out();
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] mul_35;
        logic [DATA_WIDTH-1:0] mul_neg;
`ifdef ALU_MUL_EN
        mul_35  = 32'd35;
        mul_neg = 32'hFFFF_FFDD;
`else
        mul_35  = 32'h0;
        mul_neg = 32'h0;
`endif
        RST  = 1'b0;
        OP1  = 32'h0;
        OP2  = 32'h0;
        OPRN = OPRN_ADD;
        repeat (2) @(posedge CLK);
        #1;
        check_rst("reset_state");

        @(negedge CLK);
        RST = 1'b1;

        step("add_15_3",     OPRN_ADD, 32'd15,        32'd3,         32'd18);
        step("sub_15_5",     OPRN_SUB, 32'd15,        32'd5,         32'd10);
        step("add_15_m5",    OPRN_ADD, 32'd15,        32'hFFFF_FFFB, 32'd10);
        step("sub_11_11",    OPRN_SUB, 32'd11,        32'd11,        32'd0);
        step("add_wrap",     OPRN_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0);
        step("mul_7_5",      OPRN_MUL, 32'd7,         32'd5,         mul_35);
        step("mul_m7_5",     OPRN_MUL, 32'hFFFF_FFF9, 32'd5,         mul_neg);
        step("mul_m7_m5",    OPRN_MUL, 32'hFFFF_FFF9, 32'hFFFF_FFFB, mul_35);
        step("srl_0f_2",     OPRN_SRL, 32'h0000_000F, 32'd2,         32'd3);
        step("srl_ones_2",   OPRN_SRL, 32'hFFFF_FFFF, 32'd2,         32'h3FFF_FFFF);
        step("sll_1_5",      OPRN_SLL, 32'd1,         32'd5,         32'd32);
        step("sll_ones_5",   OPRN_SLL, 32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFE0);
        step("sll_1_32",     OPRN_SLL, 32'd1,         32'd32,        32'd0);
        step("srl_big_amt",  OPRN_SRL, 32'hFFFF_FFFF, 32'h0000_0101, 32'd0);
        step("and_b_2",      OPRN_AND, 32'b1011,      32'b0010,      32'd2);
        step("or_b_2",       OPRN_OR,  32'b1011,      32'b0010,      32'd11);
        step("nor_m8_2",     OPRN_NOR, 32'hFFFF_FFF8, 32'd2,         32'd5);
        step("slt_11_15",    OPRN_SLT, 32'd11,        32'd15,        32'd1);
        step("slt_11_11",    OPRN_SLT, 32'd11,        32'd11,        32'd0);
        step("slt_unsigned", OPRN_SLT, 32'hFFFF_FFFF, 32'd1,         32'd0);
        step("oprn_00",      6'h00,    32'd5,         32'd3,         32'd0);
        step("oprn_3f",      6'h3F,    32'd5,         32'd3,         32'd0);
        step("oprn_0a",      6'h0A,    32'd5,         32'd3,         32'd0);
        step("pre_reset",    OPRN_ADD, 32'd40,        32'd2,         32'd42);

        // Mid-stream reset between edges: in-flight operation is dropped.
        @(negedge CLK);
        OPRN = OPRN_ADD;
        OP1  = 32'd100;
        OP2  = 32'd1;
        #2;
        RST = 1'b0;
        #1;
        check_rst("async_reset");
        @(posedge CLK);
        #1;
        check_rst("reset_hold");

        @(negedge CLK);
        RST = 1'b1;
        OP1 = 32'd15;
        OP2 = 32'd3;
        exp_q.push_back(32'd18);
        tag_q.push_back("post_reset_add");
        @(posedge CLK);
        #1;
        check_out();

        step("after_reset_sub", OPRN_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);

        test_cnt++;
        assert (exp_q.size() == 0) else begin
            fail_cnt++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Single-cycle 32-bit integer ALU for the project datapath, used by the execute stage. It accepts two operands and a 6-bit operation code. It produces a registered result and a zero flag one clock after the inputs are sampled. All arithmetic is modulo 2^DATA_WIDTH.

## Interface
- DATA_WIDTH, default 32: operand and result width.
- OPRN_WIDTH, default 6: operation code width.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous active-low reset.
- OP1  input  DATA_WIDTH  first operand.
- OP2  input  DATA_WIDTH  second operand; also the shift amount.
- OPRN  input  OPRN_WIDTH  operation select.
- OUT  output  DATA_WIDTH  registered result.
- ZERO  output  1  registered flag, 1 when OUT == 0.

## Operation
- 0x01 ADD: OP1 + OP2, truncated to DATA_WIDTH. Carry and overflow are discarded.
- 0x02 SUB: OP1 - OP2, two's complement, truncated.
- 0x03 MUL: low DATA_WIDTH bits of OP1 * OP2. These bits are identical for signed and unsigned operands, e.g. -7 * 5 = 0xFFFFFFDD.
- 0x04 SRL: logical right shift of OP1 by OP2.
  - OP2 is the full unsigned value.
  - OP2 >= DATA_WIDTH gives 0.
  - Zero fill, no sign extension: 0xFFFFFFFF >> 2 = 0x3FFFFFFF.
- 0x05 SLL: logical left shift of OP1 by OP2, same amount rules as SRL.
- 0x06 AND, 0x07 OR, 0x08 NOR: bitwise operations.
- 0x09 SLT: result is 1 if OP1 < OP2 as an unsigned comparison, else 0. Upper bits are zero.
- Any other code, including 0x00 and 0x0A–0x3F: result is 0.
- ZERO is derived from the same next-state result, so ZERO always matches OUT.

## Timing
- OP1, OP2 and OPRN are sampled on the rising CLK edge.
- OUT and ZERO update on that same edge: 1-cycle latency, one result per cycle, no handshake and no stall.
- Reset:
  - RST low immediately forces OUT = 0 and ZERO = 1, with no clock needed.
  - While RST is low, the outputs hold those values.
  - The first edge after RST rises loads the current inputs.
- Reset during an operation: the in-flight result is lost. There is no replay.
- Inputs that change between edges have no effect until the next edge.
- Unknown (X) inputs are not sanitized. X may propagate to OUT and ZERO.

## Configuration
- ALU_MUL_EN defined: the multiplier is built and 0x03 behaves as specified.
- ALU_MUL_EN undefined: no multiplier logic is built. 0x03 is treated as an unsupported code, giving OUT = 0 and ZERO = 1.

## Structure
- Shared package or definition file: DATA_WIDTH, OPRN_WIDTH and the named opcode constants 0x01–0x09. The datapath and the bench both import these.
- One sub-module, alu_barrel_shift:
  - Combinational, log2(DATA_WIDTH) stages.
  - Takes a direction input and performs both left and right shifts.
  - Includes out-of-range amount detection.
- The top level holds the operation mux, the adder/subtractor, the optional multiplier, the output register and the zero detect.

## Test plan
- Reset: assert RST mid-stream -> OUT = 0 and ZERO = 1 immediately. After release, the next edge loads 15 + 3, giving OUT = 18 and ZERO = 0.
- Arithmetic, one result per edge:
  - 15 + 3 -> 18.
  - 15 - 5 -> 10.
  - 15 + (-5) -> 10.
  - 11 - 11 -> 0 with ZERO = 1.
  - 0xFFFFFFFF + 1 -> 0 with ZERO = 1.
- Multiply:
  - 7 * 5 -> 35.
  - -7 * 5 -> 0xFFFFFFDD.
  - -7 * -5 -> 35.
  - With ALU_MUL_EN undefined, 7 * 5 -> 0 with ZERO = 1.
- Shifts:
  - 0x0F >> 2 -> 3.
  - 0xFFFFFFFF >> 2 -> 0x3FFFFFFF.
  - 1 << 5 -> 32.
  - 0xFFFFFFFF << 5 -> 0xFFFFFFE0.
  - 1 << 32 -> 0 with ZERO = 1.
- Logic and compare:
  - 0b1011 AND 0b0010 -> 2.
  - 0b1011 OR 0b0010 -> 11.
  - -8 NOR 2 -> 5.
  - 11 < 15 -> 1.
  - 11 < 11 -> 0 with ZERO = 1.
  - 0xFFFFFFFF < 1 -> 0, because the comparison is unsigned.
- Unsupported code: OPRN = 0x00 and OPRN = 0x3F, each with OP1 = 5 and OP2 = 3 -> OUT = 0 and ZERO = 1.
